branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Parametrised dynamic branch predictor for the RV32 5-stage pipeline. Looks up the IF-stage PC
//  in a direct-mapped branch target buffer (BTB) and returns a predicted next-PC in the same cycle.
//  Trains from resolved branches/jumps in EX and keeps branch/mispredict statistics.
//  Sits beside NPC_Generator: prediction feeds IF, update and mispredict feed EX/HarzardUnit.
// PARAMETERS
//  BTB_ENTRIES   64   BTB depth; power of two, 4..1024; IDX_W = $clog2(BTB_ENTRIES)
//  BHT_ENTRIES   256  2-bit counter table depth (BP_BHT_EN only); power of two, 4..4096
//  STAT_W        32   width of statistics counters
// PORTS
//  clk               in   1       core clock, all state updates on rising edge
//  rst_n             in   1       asynchronous active-low reset
//  pc_f              in   32      IF-stage PC to predict
//  pred_taken_f      out  1       1 = predict taken, redirect fetch to pred_target_f
//  pred_target_f     out  32      predicted target; 0 when pred_taken_f = 0
//  upd_valid         in   1       a resolved branch/jal/jalr is in EX this cycle (core gates flushes/stalls)
//  upd_pc            in   32      PC of resolved instruction
//  upd_taken         in   1       actual outcome (1 for jal/jalr)
//  upd_target        in   32      actual target
//  upd_pred_taken    in   1       prediction carried down pipeline for this instruction
//  upd_pred_target   in   32      predicted target carried down pipeline
//  upd_mispredict    out  1       combinational: upd_valid & mispredicted (see below)
//  stat_branches     out  STAT_W  count of upd_valid cycles
//  stat_mispredicts  out  STAT_W  count of upd_mispredict cycles
// BEHAVIOUR
//  - Entry e: valid, tag = PC[31:IDX_W+2], target[31:0]. Index = PC[IDX_W+1:2]; PC[1:0] ignored.
//  - Lookup combinational, zero latency: hit = valid[idx(pc_f)] & tag match.
//  - upd_mispredict = upd_valid & ((upd_pred_taken != upd_taken) | (upd_taken & upd_pred_target != upd_target)).
//  - Update at rising edge when upd_valid: taken -> write valid=1, tag, target at idx(upd_pc)
//    (allocates or overwrites alias). Not-taken handling depends on BP_BHT_EN.
//  - Same cycle lookup and update to same index: lookup returns pre-update contents; new contents
//    visible from next cycle. No bypass.
//  - Statistics: increment on upd_valid / upd_mispredict; saturate at all-ones, never wrap.
//  - Reset (async, any time incl. mid-update): all valid=0, BHT counters=2'b01, stats=0;
//    outputs immediately pred_taken_f=0, pred_target_f=0, stats=0. Pending update is dropped.
//  - upd_valid=0: no state change; upd_mispredict=0.
// CONFIGURATION
//  BP_BHT_EN defined:
//   - Adds BHT of BHT_ENTRIES 2-bit saturating counters, index = PC[$clog2(BHT_ENTRIES)+1:2].
//   - pred_taken_f = hit & counter[1]. On upd_valid: taken -> counter+1 (sat 11), not-taken ->
//     counter-1 (sat 00). BTB written on taken only; never invalidated on not-taken.
//  BP_BHT_EN undefined:
//   - No BHT; pred_taken_f = hit. Not-taken update that hits BTB clears that entry's valid;
//     not-taken miss: no change.
// TESTING
//  1 Reset, pc_f=0x100 -> pred_taken_f=0, pred_target_f=0, stats=0.
//  2 upd pc=0x100 taken tgt=0x200 pred_taken=0 -> upd_mispredict=1 that cycle; next cycle pc_f=0x100
//    -> taken, tgt 0x200 (BHT: counter 01->10); stat_branches=1, stat_mispredicts=1.
//  3 BTB_ENTRIES=64: after test 2, pc_f=0x200 (same index, tag differs) -> pred_taken_f=0;
//    update 0x200 taken tgt 0x40 -> pc_f=0x100 now misses.
//  4 Two not-taken updates at 0x100 after saturating to 11: BHT -> 11->10->01, predicts not-taken,
//    BTB still valid; no BHT -> entry invalidated after first.
//  5 upd 0x300 taken tgt 0x80 with pc_f=0x300 same cycle -> old (miss) this cycle, hit next cycle.
//  6 Assert rst_n low between clock edges mid-run -> outputs and stats 0 before next edge;
//    stats at all-ones stay all-ones on further updates (STAT_W=4 build).

Source files
------------

// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor: direct-mapped BTB with zero-latency lookup for the
// IF-stage PC, training from resolved branches/jumps in EX, and saturating
// branch/mispredict statistics.
// Optional feature macro: BP_BHT_EN adds a table of 2-bit saturating counters
// that qualifies BTB hits. Without it, a BTB hit predicts taken and a
// not-taken resolution that hits the BTB invalidates the entry.
// Update interface: upd_valid is a single-cycle qualifier with no
// back-pressure. Every cycle it is high, one resolved instruction is consumed.
module branch_predict_unit #(
    parameter int BTB_ENTRIES = 64,
    parameter int BHT_ENTRIES = 256,
    parameter int STAT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pc_f,
    output logic              pred_taken_f,
    output logic [31:0]       pred_target_f,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    input  logic [31:0]       upd_pred_target,
    output logic              upd_mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // Elaboration-time guards on table geometry.
    if (BTB_ENTRIES < 4 || BTB_ENTRIES > 1024 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_btb_bad
        $error("BTB_ENTRIES must be a power of two in 4..1024");
    end
    if (BHT_ENTRIES < 4 || BHT_ENTRIES > 4096 || (BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0) begin : g_bht_bad
        $error("BHT_ENTRIES must be a power of two in 4..4096");
    end

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];

    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic [IDX_W-1:0] idx_u;
    logic [TAG_W-1:0] tag_u;
    logic             hit_f;
    logic             btb_clear;

    // Byte offset within the word never affects prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_f[1:0], upd_pc[1:0]};

    assign idx_f = pc_f[IDX_W+1:2];
    assign tag_f = pc_f[31:IDX_W+2];
    assign idx_u = upd_pc[IDX_W+1:2];
    assign tag_u = upd_pc[31:IDX_W+2];

    // Lookup reads the current array contents; same-cycle updates are not bypassed.
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

`ifdef BP_BHT_EN
    localparam int BHT_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [BHT_W-1:0] bht_idx_f;
    logic [BHT_W-1:0] bht_idx_u;

    assign bht_idx_f    = pc_f[BHT_W+1:2];
    assign bht_idx_u    = upd_pc[BHT_W+1:2];
    assign pred_taken_f = hit_f & bht_q[bht_idx_f][1];
    // Entries stay valid on not-taken; the counter alone suppresses the prediction.
    assign btb_clear    = 1'b0;

    // 2-bit saturating counters, reset to weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (upd_valid) begin
            if (upd_taken && bht_q[bht_idx_u] != 2'b11)
                bht_q[bht_idx_u] <= bht_q[bht_idx_u] + 2'b01;
            else if (!upd_taken && bht_q[bht_idx_u] != 2'b00)
                bht_q[bht_idx_u] <= bht_q[bht_idx_u] - 2'b01;
        end
    end
`else
    logic hit_u;

    assign hit_u        = valid_q[idx_u] && (tag_q[idx_u] == tag_u);
    assign pred_taken_f = hit_f;
    // Without counters, a not-taken outcome that hits the BTB evicts the entry.
    assign btb_clear    = ~upd_taken & hit_u;
`endif

    assign pred_target_f  = pred_taken_f ? target_q[idx_f] : 32'h0;
    assign upd_mispredict = upd_valid &
                            ((upd_pred_taken != upd_taken) |
                             (upd_taken & (upd_pred_target != upd_target)));

    // Valid bits: allocate/overwrite on taken, optionally clear on not-taken hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (upd_valid && upd_taken) begin
            valid_q[idx_u] <= 1'b1;
        end else if (upd_valid && btb_clear) begin
            valid_q[idx_u] <= 1'b0;
        end
    end

    // Tag/target payload; qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag_q[idx_u]    <= tag_u;
            target_q[idx_u] <= upd_target;
        end
    end

    // Statistics counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd_valid && stat_branches != {STAT_W{1'b1}})
                stat_branches <= stat_branches + 1'b1;
            if (upd_mispredict && stat_mispredicts != {STAT_W{1'b1}})
                stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit (BTB_ENTRIES=64, STAT_W=4).
// Expectations follow the BP_BHT_EN setting of the build.
module tb_branch_predict_unit;

    localparam int STAT_W = 4;
    localparam int SAT    = 15;

    logic              clk;
    logic              rst_n;
    logic [31:0]       pc_f;
    logic              pred_taken_f;
    logic [31:0]       pred_target_f;
    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_pred_taken;
    logic [31:0]       upd_pred_target;
    logic              upd_mispredict;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    int n_cmp = 0;
    int n_bad = 0;
    int n_br  = 0;
    int n_mp  = 0;
    logic exp_p;

    branch_predict_unit #(
        .BTB_ENTRIES(64),
        .BHT_ENTRIES(256),
        .STAT_W(STAT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pc_f(pc_f),
        .pred_taken_f(pred_taken_f),
        .pred_target_f(pred_target_f),
        .upd_valid(upd_valid),
        .upd_pc(upd_pc),
        .upd_taken(upd_taken),
        .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .upd_mispredict(upd_mispredict),
        .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int n);
        return (n > SAT) ? SAT : n;
    endfunction

    task automatic check_stats(input string tag);
        check_eq({tag, "_branches"}, {28'h0, stat_branches}, sat(n_br));
        check_eq({tag, "_mispredicts"}, {28'h0, stat_mispredicts}, sat(n_mp));
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        pc_f = pc;
        #1;
        check_eq({tag, "_taken"}, pred_taken_f, taken);
        check_eq({tag, "_target"}, pred_target_f, tgt);
    endtask

    // Drive one resolved instruction for a single clock edge.
    task automatic do_update(input string tag, input logic [31:0] pc, input logic taken,
                             input logic [31:0] tgt, input logic ptaken,
                             input logic [31:0] ptgt, input logic exp_mp);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = taken;
        upd_target      = tgt;
        upd_pred_taken  = ptaken;
        upd_pred_target = ptgt;
        #1;
        check_eq({tag, "_mispredict"}, upd_mispredict, exp_mp);
        @(posedge clk);
        #1;
        n_br++;
        if (exp_mp) n_mp++;
        upd_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        pc_f = 32'h100;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_taken = 1'b0;
        upd_target = '0;
        upd_pred_taken = 1'b0;
        upd_pred_target = '0;
`ifdef BP_BHT_EN
        exp_p = 1'b1;
`else
        exp_p = 1'b0;
`endif

        // Reset state
        #2;
        check_pred("rst", 32'h100, 1'b0, 32'h0);
        check_stats("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First taken branch allocates
        do_update("t2", 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
        check_pred("t2", 32'h100, 1'b1, 32'h200);
        check_stats("t2");

        // Alias at same index, different tag
        check_pred("t3_alias_miss", 32'h200, 1'b0, 32'h0);
        do_update("t3", 32'h200, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        check_pred("t3_new", 32'h200, 1'b1, 32'h40);
        check_pred("t3_old_miss", 32'h100, 1'b0, 32'h0);
        check_stats("t3");

        // Re-train 0x100 to strongly taken, then two not-taken outcomes
        do_update("t4a", 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
        do_update("t4b", 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
        check_pred("t4_hit", 32'h100, 1'b1, 32'h200);
        do_update("t4c", 32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
        check_pred("t4_after1", 32'h100, exp_p, exp_p ? 32'h200 : 32'h0);
        do_update("t4d", 32'h100, 1'b0, 32'h0, exp_p, exp_p ? 32'h200 : 32'h0, exp_p);
        check_pred("t4_after2", 32'h100, 1'b0, 32'h0);
        check_stats("t4");

        // Same-cycle lookup and update to the same index: no bypass
        pc_f            = 32'h300;
        upd_valid       = 1'b1;
        upd_pc          = 32'h300;
        upd_taken       = 1'b1;
        upd_target      = 32'h80;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;
        #1;
        check_eq("t5_same_cycle_taken", pred_taken_f, 1'b0);
        check_eq("t5_same_cycle_target", pred_target_f, 32'h0);
        check_eq("t5_mispredict", upd_mispredict, 1'b1);
        @(posedge clk);
        #1;
        n_br++;
        n_mp++;
        upd_valid = 1'b0;
        check_pred("t5_next", 32'h300, 1'b1, 32'h80);
        check_pred("t5_low_bits", 32'h302, 1'b1, 32'h80);

        // Idle cycle with disagreeing fields must not count or flag
        upd_taken = 1'b0;
        upd_pred_taken = 1'b1;
        #1;
        check_eq("idle_mispredict", upd_mispredict, 1'b0);
        @(posedge clk);
        #1;
        check_stats("idle");

        // Direction correct but target wrong is a mispredict
        do_update("tgt_wrong", 32'h300, 1'b1, 32'h84, 1'b1, 32'h80, 1'b1);
        check_pred("tgt_wrong", 32'h300, 1'b1, 32'h84);
        check_stats("tgt_wrong");

        // Asynchronous reset between edges with an update pending
        upd_valid       = 1'b1;
        upd_pc          = 32'h500;
        upd_taken       = 1'b1;
        upd_target      = 32'h10;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;
        #2;
        rst_n = 1'b0;
        #1;
        n_br = 0;
        n_mp = 0;
        check_eq("arst_taken", pred_taken_f, 1'b0);
        check_eq("arst_target", pred_target_f, 32'h0);
        check_stats("arst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        upd_valid = 1'b0;
        check_pred("arst_dropped", 32'h500, 1'b0, 32'h0);
        check_pred("arst_cleared", 32'h300, 1'b0, 32'h0);
        check_stats("arst_after");

        // Statistics saturation
        for (int i = 0; i < 18; i++) begin
            do_update("sat", 32'h400, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
            check_stats("sat");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
